affine_mcm_seq_ctrl: RTL and testbench
======================================

// Module: affine_mcm_seq_ctrl
// PURPOSE
//  Sequencer for the shared 6-tap 1/16-precision affine MCM interpolation datapath (tap MCM blocks t0..t5).
//  Per affine sub-block: runs a horizontal pass over the reference rows, then a vertical pass over columns.
//  Drives the phase select (Y1..Y15 choice), pass mode, row fetch and output-valid strobes.
//  Sits between the affine MV/sub-block scheduler and the filter/line-buffer datapath.
// PARAMETERS
//  SB_W   4  sub-block width, samples (columns filtered in the vertical pass)
//  SB_H   4  sub-block height, output rows
//  TAPS   6  filter length; horizontal pass reads SB_H+TAPS-1 rows
//  RW     4  width of row/column index outputs; must satisfy 2**RW >= SB_H+TAPS-1
// PORTS
//  clk          in   1    clock, rising edge
//  rst_n        in   1    asynchronous active-low reset
//  start_i      in   1    start sub-block; sampled only when ready_o=1
//  frac_x_i     in   4    horizontal phase 0..15 (0 = integer position)
//  frac_y_i     in   4    vertical phase 0..15
//  ready_o      out  1    1 in IDLE
//  row_req_o    out  1    request reference row row_idx_o from the fetch unit
//  row_idx_o    out  RW   requested row index (0 = top of TAPS-1 margin)
//  row_vld_i    in   1    fetch unit: row present on datapath this cycle (completes request)
//  filt_en_o    out  1    datapath: capture/filter current data this cycle
//  pass_o       out  1    0 = horizontal pass, 1 = vertical pass
//  phase_o      out  4    MCM output select (frac_x in H pass, frac_y in V pass)
//  bypass_o     out  1    1 = integer phase, datapath copies centre tap (w1 path), no shift
//  col_idx_o    out  RW   column under vertical filtering
//  out_vld_o    out  1    vertical-pass result valid
//  out_rdy_i    in   1    consumer accepts result (out_vld_o & out_rdy_i)
//  done_o       out  1    one-cycle pulse after last result accepted
// BEHAVIOUR
//  Reset: state=IDLE; ready_o=1; all other outputs 0 (row_idx_o, col_idx_o, phase_o = 0).
//  Start: start_i & ready_o registers frac_x/frac_y; next cycle enters HPASS. start_i ignored while busy.
//  HPASS: row range R0..R1; frac_y!=0 -> R0=0, R1=SB_H+TAPS-2; frac_y==0 -> R0=TAPS/2-1, R1=R0+SB_H-1.
//   row_req_o=1, row_idx_o=current row, held stable until row_vld_i=1.
//   Cycle with row_vld_i=1: filt_en_o=1, pass_o=0, phase_o=frac_x, bypass_o=(frac_x==0).
//   Row index increments after each accepted row. Back-to-back rows are allowed (one row/cycle max).
//   After row R1 is accepted, next state is VPASS. row_vld_i with row_req_o=0 is ignored.
//  VPASS: col_idx_o 0..SB_W-1 for each output row 0..SB_H-1, raster order (col fastest).
//   out_vld_o=1, pass_o=1, phase_o=frac_y, bypass_o=(frac_y==0), filt_en_o = out_vld_o & out_rdy_i.
//   Index advances only on the out_vld_o & out_rdy_i handshake. out_vld_o stays high under stall;
//   col_idx_o and phase_o stay stable under stall.
//   Last handshake (row SB_H-1, col SB_W-1) moves to DONE.
//  DONE: done_o=1 for exactly one cycle, then IDLE (ready_o=1 on the following cycle).
//  States: IDLE->HPASS (start), HPASS->VPASS (last row), VPASS->DONE (last beat), DONE->IDLE.
//  Latency, no stalls: frac_y!=0 -> 1 + (SB_H+TAPS-1) + SB_W*SB_H + 1 cycles, start to done_o.
//  Reset mid-operation: asynchronous return to IDLE with reset values; no done_o is produced.
//  Counters: no wrap-around beyond the R1 and SB_W*SB_H limits; no counter aliasing for legal parameters.
// CONFIGURATION
//  AFFINE_SEQ_PERF_EN defined: adds ports busy_cyc_o[15:0] and stall_cyc_o[15:0].
//   busy_cyc_o counts non-IDLE cycles.
//   stall_cyc_o counts cycles with (row_req_o & !row_vld_i) or (out_vld_o & !out_rdy_i).
//   Both counters saturate at 16'hFFFF and are cleared by rst_n only.
//  AFFINE_SEQ_PERF_EN undefined: those ports and counters are absent; all other behaviour is identical.
// TESTING
//  1 Reset: rst_n=0 -> ready_o=1, every other output 0. Release rst_n -> still IDLE.
//  2 frac_x=5, frac_y=11, row_vld_i=1, out_rdy_i=1:
//    9 H rows (idx 0..8, phase 5), then 16 V beats (phase 11). done_o at cycle 27 after start.
//  3 frac_x=0, frac_y=0: rows 2..5 only, bypass_o=1 in both passes. 4 H + 16 V beats, done_o once.
//  4 row_vld_i low 3 cycles on row 4: row_idx_o holds 4, no filt_en_o.
//    out_rdy_i low 2 cycles on beat 7: col_idx_o/out_vld_o hold. Total beat count unchanged.
//  5 start_i pulsed during VPASS -> ignored. rst_n pulsed during HPASS row 3 -> IDLE, no done_o.
//    A new start then runs a full, correct sequence.
//  6 AFFINE_SEQ_PERF_EN, test 4 stimulus -> stall_cyc_o=5, busy_cyc_o=32 after done.

Source files
------------

// File: rtl/affine_mcm_seq_ctrl.sv
// Sequencer for the shared 6-tap affine MCM interpolation datapath: H pass over rows, then V pass over columns.
// Optional performance counters (busy/stall cycles) are enabled with `define AFFINE_SEQ_PERF_EN.
module affine_mcm_seq_ctrl #(
    parameter int SB_W = 4,
    parameter int SB_H = 4,
    parameter int TAPS = 6,
    parameter int RW   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [3:0]    frac_x_i,
    input  logic [3:0]    frac_y_i,
    output logic          ready_o,
    output logic          row_req_o,
    output logic [RW-1:0] row_idx_o,
    input  logic          row_vld_i,
    output logic          filt_en_o,
    output logic          pass_o,
    output logic [3:0]    phase_o,
    output logic          bypass_o,
    output logic [RW-1:0] col_idx_o,
    output logic          out_vld_o,
    input  logic          out_rdy_i,
    output logic          done_o
`ifdef AFFINE_SEQ_PERF_EN
    ,
    output logic [15:0]   busy_cyc_o,
    output logic [15:0]   stall_cyc_o
`endif
);

    // state   | meaning
    // S_IDLE  | waiting for start, ready_o=1
    // S_LOAD  | phases captured, row range selected from frac_y
    // S_HPASS | horizontal pass, one reference row per row_vld_i
    // S_VPASS | vertical pass, one output beat per out_vld_o & out_rdy_i
    // S_DONE  | one-cycle done_o pulse
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HPASS, S_VPASS, S_DONE} state_t;

    localparam logic [RW-1:0] ROW_FIRST_FULL = '0;
    localparam logic [RW-1:0] ROW_LAST_FULL  = RW'(SB_H + TAPS - 2);
    localparam logic [RW-1:0] ROW_FIRST_INT  = RW'(TAPS / 2 - 1);
    localparam logic [RW-1:0] ROW_LAST_INT   = RW'(TAPS / 2 - 1 + SB_H - 1);
    localparam logic [RW-1:0] COL_LAST       = RW'(SB_W - 1);
    localparam logic [RW-1:0] VROW_LAST      = RW'(SB_H - 1);

    state_t        state;
    logic [3:0]    frac_x;
    logic [3:0]    frac_y;
    logic [RW-1:0] row;
    logic [RW-1:0] row_last;
    logic [RW-1:0] col;
    logic [RW-1:0] vrow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            frac_x   <= '0;
            frac_y   <= '0;
            row      <= '0;
            row_last <= '0;
            col      <= '0;
            vrow     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        frac_x <= frac_x_i;
                        frac_y <= frac_y_i;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Integer vertical phase needs only the SB_H rows under the centre tap.
                    if (frac_y != 4'd0) begin
                        row      <= ROW_FIRST_FULL;
                        row_last <= ROW_LAST_FULL;
                    end else begin
                        row      <= ROW_FIRST_INT;
                        row_last <= ROW_LAST_INT;
                    end
                    state <= S_HPASS;
                end
                S_HPASS: begin
                    if (row_vld_i) begin
                        if (row == row_last) begin
                            col   <= '0;
                            vrow  <= '0;
                            state <= S_VPASS;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end
                end
                S_VPASS: begin
                    if (out_rdy_i) begin
                        if (col == COL_LAST) begin
                            col <= '0;
                            if (vrow == VROW_LAST) begin
                                state <= S_DONE;
                            end else begin
                                vrow <= vrow + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ready_o   = (state == S_IDLE);
    assign row_req_o = (state == S_HPASS);
    assign row_idx_o = (state == S_HPASS) ? row : '0;
    assign out_vld_o = (state == S_VPASS);
    assign col_idx_o = (state == S_VPASS) ? col : '0;
    assign pass_o    = (state == S_VPASS);
    assign done_o    = (state == S_DONE);
    assign filt_en_o = (row_req_o & row_vld_i) | (out_vld_o & out_rdy_i);

    always_comb begin
        phase_o  = 4'd0;
        bypass_o = 1'b0;
        if (state == S_HPASS) begin
            phase_o  = frac_x;
            bypass_o = (frac_x == 4'd0);
        end else if (state == S_VPASS) begin
            phase_o  = frac_y;
            bypass_o = (frac_y == 4'd0);
        end
    end

`ifdef AFFINE_SEQ_PERF_EN
    logic stall;
    assign stall = (row_req_o & ~row_vld_i) | (out_vld_o & ~out_rdy_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cyc_o  <= '0;
            stall_cyc_o <= '0;
        end else begin
            if (state != S_IDLE && busy_cyc_o != 16'hFFFF) begin
                busy_cyc_o <= busy_cyc_o + 16'd1;
            end
            if (stall && stall_cyc_o != 16'hFFFF) begin
                stall_cyc_o <= stall_cyc_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_affine_mcm_seq_ctrl.sv
// Bench for affine_mcm_seq_ctrl: directed and randomized sub-block runs against an expected row/beat list.
// Define AFFINE_SEQ_PERF_EN to also check the performance counters.
module tb_affine_mcm_seq_ctrl;
    localparam int SB_W = 4;
    localparam int SB_H = 4;
    localparam int TAPS = 6;
    localparam int RW   = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic [3:0]    frac_x_i = '0;
    logic [3:0]    frac_y_i = '0;
    logic          row_vld_i = 1'b0;
    logic          out_rdy_i = 1'b0;
    logic          ready_o, row_req_o, filt_en_o, pass_o, bypass_o, out_vld_o, done_o;
    logic [RW-1:0] row_idx_o, col_idx_o;
    logic [3:0]    phase_o;
`ifdef AFFINE_SEQ_PERF_EN
    logic [15:0]   busy_cyc_o, stall_cyc_o;
`endif

    int tests = 0;
    int fails = 0;

    affine_mcm_seq_ctrl #(.SB_W(SB_W), .SB_H(SB_H), .TAPS(TAPS), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .frac_x_i(frac_x_i), .frac_y_i(frac_y_i),
        .ready_o(ready_o), .row_req_o(row_req_o), .row_idx_o(row_idx_o), .row_vld_i(row_vld_i),
        .filt_en_o(filt_en_o), .pass_o(pass_o), .phase_o(phase_o), .bypass_o(bypass_o),
        .col_idx_o(col_idx_o), .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i), .done_o(done_o)
`ifdef AFFINE_SEQ_PERF_EN
        , .busy_cyc_o(busy_cyc_o), .stall_cyc_o(stall_cyc_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"},  32'(ready_o),   32'd1);
        check({tag, "_req"},    32'(row_req_o), 32'd0);
        check({tag, "_rowidx"}, 32'(row_idx_o), 32'd0);
        check({tag, "_filt"},   32'(filt_en_o), 32'd0);
        check({tag, "_pass"},   32'(pass_o),    32'd0);
        check({tag, "_phase"},  32'(phase_o),   32'd0);
        check({tag, "_bypass"}, 32'(bypass_o),  32'd0);
        check({tag, "_colidx"}, 32'(col_idx_o), 32'd0);
        check({tag, "_outvld"}, 32'(out_vld_o), 32'd0);
        check({tag, "_done"},   32'(done_o),    32'd0);
    endtask

    // One full sub-block. Expected rows/beats come from the row-range and raster rules.
    task automatic run_seq(input logic [3:0] fx, input logic [3:0] fy,
                           input int hold_row, input int hold_n,
                           input int hold_beat, input int rdy_n,
                           input bit rnd, input int glitch_beat);
        int r0, r1, n;
        r0 = (fy != 0) ? 0 : TAPS / 2 - 1;
        r1 = (fy != 0) ? SB_H + TAPS - 2 : r0 + SB_H - 1;
        @(negedge clk);
        start_i = 1'b1; frac_x_i = fx; frac_y_i = fy; row_vld_i = 1'b0; out_rdy_i = 1'b0;
        #1 check("start_ready", 32'(ready_o), 32'd1);
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0; frac_x_i = 4'($urandom); frac_y_i = 4'($urandom); row_vld_i = 1'b1;
        #1 check("load_ready", 32'(ready_o), 32'd0);
        check("load_req", 32'(row_req_o), 32'd0);
        check("load_filt", 32'(filt_en_o), 32'd0);
        @(posedge clk);
        for (int r = r0; r <= r1; r++) begin
            n = (r == hold_row) ? hold_n : (rnd ? int'($urandom_range(2, 0)) : 0);
            for (int k = 0; k < n; k++) begin
                @(negedge clk); row_vld_i = 1'b0;
                #1 check("hstall_req", 32'(row_req_o), 32'd1);
                check("hstall_idx", 32'(row_idx_o), 32'(r));
                check("hstall_filt", 32'(filt_en_o), 32'd0);
                @(posedge clk);
            end
            @(negedge clk); row_vld_i = 1'b1;
            #1 check("h_req", 32'(row_req_o), 32'd1);
            check("h_idx", 32'(row_idx_o), 32'(r));
            check("h_filt", 32'(filt_en_o), 32'd1);
            check("h_pass", 32'(pass_o), 32'd0);
            check("h_phase", 32'(phase_o), 32'(fx));
            check("h_bypass", 32'(bypass_o), 32'(fx == 4'd0));
            check("h_outvld", 32'(out_vld_o), 32'd0);
            check("h_done", 32'(done_o), 32'd0);
            @(posedge clk);
        end
        for (int b = 0; b < SB_W * SB_H; b++) begin
            n = (b == hold_beat) ? rdy_n : (rnd ? int'($urandom_range(2, 0)) : 0);
            for (int k = 0; k < n; k++) begin
                @(negedge clk); out_rdy_i = 1'b0; row_vld_i = 1'($urandom);
                #1 check("vstall_vld", 32'(out_vld_o), 32'd1);
                check("vstall_col", 32'(col_idx_o), 32'(b % SB_W));
                check("vstall_phase", 32'(phase_o), 32'(fy));
                check("vstall_filt", 32'(filt_en_o), 32'd0);
                @(posedge clk);
            end
            @(negedge clk); out_rdy_i = 1'b1; row_vld_i = 1'($urandom);
            start_i = (b == glitch_beat);
            #1 check("v_vld", 32'(out_vld_o), 32'd1);
            check("v_col", 32'(col_idx_o), 32'(b % SB_W));
            check("v_filt", 32'(filt_en_o), 32'd1);
            check("v_pass", 32'(pass_o), 32'd1);
            check("v_phase", 32'(phase_o), 32'(fy));
            check("v_bypass", 32'(bypass_o), 32'(fy == 4'd0));
            check("v_req", 32'(row_req_o), 32'd0);
            check("v_ready", 32'(ready_o), 32'd0);
            check("v_done", 32'(done_o), 32'd0);
            @(posedge clk);
        end
        @(negedge clk); out_rdy_i = 1'b0; row_vld_i = 1'b0; start_i = 1'b0;
        #1 check("done_pulse", 32'(done_o), 32'd1);
        check("done_ready", 32'(ready_o), 32'd0);
        check("done_outvld", 32'(out_vld_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1 check("post_done", 32'(done_o), 32'd0);
        check("post_ready", 32'(ready_o), 32'd1);
        check("post_req", 32'(row_req_o), 32'd0);
    endtask

    initial begin
        // Reset state
        #2 check_idle_outputs("rst");
`ifdef AFFINE_SEQ_PERF_EN
        check("rst_busy", 32'(busy_cyc_o), 32'd0);
        check("rst_stall", 32'(stall_cyc_o), 32'd0);
`endif
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1 check_idle_outputs("rel");

        // Stalls on row 4 (3 cycles) and beat 7 (2 cycles), right after reset so counters are fresh
        run_seq(4'd3, 4'd7, 4, 3, 7, 2, 1'b0, -1);
`ifdef AFFINE_SEQ_PERF_EN
        check("perf_stall", 32'(stall_cyc_o), 32'd5);
        check("perf_busy", 32'(busy_cyc_o), 32'd32);
`endif

        // No-stall fractional and integer-phase runs
        run_seq(4'd5, 4'd11, -1, 0, -1, 0, 1'b0, -1);
        run_seq(4'd0, 4'd0, -1, 0, -1, 0, 1'b0, -1);

        // start_i during the vertical pass must be ignored
        run_seq(4'd9, 4'd2, -1, 0, -1, 0, 1'b0, 5);

        // Reset during the horizontal pass at row 3
        @(negedge clk);
        start_i = 1'b1; frac_x_i = 4'd6; frac_y_i = 4'd13;
        @(posedge clk);
        @(negedge clk); start_i = 1'b0; row_vld_i = 1'b1;
        for (int r = 0; r < 4; r++) begin
            @(posedge clk);
            @(negedge clk);
        end
        row_vld_i = 1'b0;
        #1 check("abort_idx", 32'(row_idx_o), 32'd3);
        #1 rst_n = 1'b0;
        #1 check_idle_outputs("abort");
`ifdef AFFINE_SEQ_PERF_EN
        check("abort_busy", 32'(busy_cyc_o), 32'd0);
`endif
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1 check("abort_nodone", 32'(done_o), 32'd0);
            check("abort_ready", 32'(ready_o), 32'd1);
        end
        run_seq(4'd5, 4'd11, -1, 0, -1, 0, 1'b0, -1);

        // Randomized phases and stalls
        for (int i = 0; i < 8; i++) begin
            logic [3:0] fx, fy;
            fx = 4'($urandom);
            fy = (i % 3 == 0) ? 4'd0 : 4'($urandom);
            run_seq(fx, fy, -1, 0, -1, 0, 1'b1, (i % 2 == 0) ? int'($urandom_range(15, 0)) : -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
